riscv_fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the PC, fetches from instruction memory over a req/gnt/rvalid
//  bus and presents one instruction word (with its PC) to the decode/control path via valid/ready.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/riscv_fetch_unit_chk.sv | 28 ++
 rtl/riscv_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: machine width, instruction width and fetch FSM encoding.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/riscv_fetch_unit_chk.sv
// Protocol and invariant checks for the fetch unit; observation only, drives nothing.
module riscv_fetch_unit_chk
  import riscv_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  input fetch_state_e    state,
  input logic            imem_req,
  input logic [XLEN-1:0] imem_addr,
  input logic            imem_gnt,
  input logic            imem_rvalid,
  input logic            inst_valid,
  input logic            drop
);

  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> state == FS_WAIT)
    else $error("fetch_chk: imem rvalid outside WAIT");

  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_gnt) |=> (imem_req && $stable(imem_addr)))
    else $error("fetch_chk: request withdrawn or address moved before grant");

  a_no_valid_on_drop: assert property (@(posedge clk) disable iff (!rst_n)
    (state == FS_WAIT && drop && imem_rvalid) |=> !inst_valid)
    else $error("fetch_chk: dropped response presented");

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs one imem transaction at a time and
// presents each fetched word with its PC; redirects discard any stale in-flight fetch.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              INST_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_req,
  output logic [XLEN-1:0]   o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [XLEN-1:0]   o_inst_pc,
  input  logic              i_redirect,
  input  logic [XLEN-1:0]   i_redirect_target,
  output logic              o_misalign
);

  fetch_state_e      state_r;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   addr_r;
  logic              drop_r;
  logic              req_r;
  logic [INST_W-1:0] inst_r;
  logic [XLEN-1:0]   inst_pc_r;
  logic              inst_valid_r;
  logic              misalign_r;

  logic [XLEN-1:0]   tgt_pc_s;
  logic [XLEN-1:0]   cur_pc_s;
  logic [XLEN-1:0]   pc_inc_s;

  // cur_pc_s is the PC that a request launched this cycle must use (a redirect wins)
  assign tgt_pc_s = align_word(i_redirect_target);
  assign cur_pc_s = i_redirect ? tgt_pc_s : pc_r;
  assign pc_inc_s = pc_r + 32'd4;

  // Fetch FSM with PC, drop flag and all output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= FS_IDLE;
      pc_r         <= RESET_PC;
      addr_r       <= RESET_PC;
      drop_r       <= 1'b0;
      req_r        <= 1'b0;
      inst_r       <= '0;
      inst_pc_r    <= '0;
      inst_valid_r <= 1'b0;
      misalign_r   <= 1'b0;
    end else begin
      misalign_r <= i_redirect & (i_redirect_target[1:0] != 2'b00);
      case (state_r)
        FS_IDLE: begin
          state_r <= FS_REQ;
          req_r   <= 1'b1;
          addr_r  <= cur_pc_s;
        end
        FS_REQ: begin
          // address stays put until the grant even if a redirect lands here
          if (i_imem_gnt) begin
            state_r <= FS_WAIT;
            req_r   <= 1'b0;
          end else begin
            state_r <= FS_REQ;
            req_r   <= 1'b1;
          end
          drop_r <= drop_r | i_redirect;
        end
        FS_WAIT: begin
          if (i_imem_rvalid) begin
            drop_r <= 1'b0;
            if (drop_r || i_redirect) begin
              state_r <= FS_REQ;
              req_r   <= 1'b1;
              addr_r  <= cur_pc_s;
            end else begin
              state_r      <= FS_HOLD;
              inst_r       <= i_imem_rdata;
              inst_pc_r    <= pc_r;
              inst_valid_r <= 1'b1;
            end
          end else begin
            state_r <= FS_WAIT;
            drop_r  <= drop_r | i_redirect;
          end
        end
        FS_HOLD: begin
          if (i_redirect) begin
            state_r      <= FS_REQ;
            req_r        <= 1'b1;
            inst_valid_r <= 1'b0;
            addr_r       <= tgt_pc_s;
          end else if (i_inst_ready) begin
            state_r      <= FS_REQ;
            req_r        <= 1'b1;
            inst_valid_r <= 1'b0;
            pc_r         <= pc_inc_s;
            addr_r       <= pc_inc_s;
          end else begin
            state_r <= FS_HOLD;
          end
        end
        default: begin
          state_r      <= FS_IDLE;
          req_r        <= 1'b0;
          drop_r       <= 1'b0;
          inst_valid_r <= 1'b0;
        end
      endcase
      if (i_redirect) begin
        pc_r <= tgt_pc_s;
      end
    end
  end

  assign o_imem_req   = req_r;
  assign o_imem_addr  = addr_r;
  assign o_inst_valid = inst_valid_r;
  assign o_inst       = inst_r;
  assign o_inst_pc    = inst_pc_r;
  assign o_misalign   = misalign_r;

  riscv_fetch_unit_chk u_chk (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .state       (state_r),
    .imem_req    (req_r),
    .imem_addr   (addr_r),
    .imem_gnt    (i_imem_gnt),
    .imem_rvalid (i_imem_rvalid),
    .inst_valid  (inst_valid_r),
    .drop        (drop_r)
  );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: a memory/consumer driver predicts the PC stream,
// a monitor pops a prediction whenever a new instruction is presented.
module tb_riscv_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect, misalign;
  logic [31:0] redirect_target;

  riscv_fetch_unit #(.RESET_PC(RESET_PC), .INST_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(imem_gnt),
    .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready), .o_inst(inst), .o_inst_pc(inst_pc),
    .i_redirect(redirect), .i_redirect_target(redirect_target), .o_misalign(misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: PCs the fetch unit is still expected to present, in order
  logic [31:0] exp_q[$];
  logic [31:0] pres_pc_q[$];
  int          pres_cyc_q[$];
  int          pres_cnt = 0;
  int          cyc = 0;
  logic [31:0] cur_pc = 32'h0;
  logic        mis_exp = 1'b0;
  logic        saw_mis = 1'b0;

  // stimulus knobs
  int   ready_pct = 100, redir_pct = 0, gnt_cfg = 0, lat_cfg = 1;
  logic rand_timing = 1'b0;
  logic force_redir = 1'b0, force_in_wait = 1'b0;
  logic [31:0] force_target = 32'h0;

  // memory model state
  logic        mem_pending = 1'b0;
  logic [31:0] mem_addr = 32'h0, held_addr = 32'h0;
  int          mem_cnt = 0, req_run = 0, last_req_run = 0, cur_gnt_delay = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic wait_pres(input int n, input int budget, input string name);
    int goal = pres_cnt + n;
    int spent = 0;
    while (pres_cnt < goal && spent < budget) begin
      @(posedge clk); #2;
      spent++;
    end
    if (pres_cnt < goal) fail({name, "_timeout"});
  endtask

  task automatic wait_force(input string name);
    int spent = 0;
    while (force_redir && spent < 200) begin
      @(posedge clk); #2;
      spent++;
    end
    if (force_redir) fail({name, "_force_timeout"});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},      {31'd0, imem_req},   32'd0);
    check({tag, "_addr"},     imem_addr,           RESET_PC);
    check({tag, "_valid"},    {31'd0, inst_valid}, 32'd0);
    check({tag, "_inst"},     inst,                32'd0);
    check({tag, "_inst_pc"},  inst_pc,             32'd0);
    check({tag, "_misalign"}, {31'd0, misalign},   32'd0);
  endtask

  // Driver: memory responder and consumer, deciding inputs for the next rising edge
  initial begin : driver
    logic in_wait;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
        mem_pending = 1'b0; req_run = 0; mis_exp = 1'b0;
        continue;
      end
      in_wait = mem_pending;
      if (imem_req) begin
        if (mem_pending) fail("second_outstanding_request");
        if (req_run > 0) check("addr_stable_until_gnt", imem_addr, held_addr);
        else held_addr = imem_addr;
      end else if (req_run > 0) begin
        fail("req_withdrawn_before_gnt");
        req_run = 0;
      end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom;
      if (mem_pending) begin
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1; imem_rdata = mem_word(mem_addr); mem_pending = 1'b0;
        end else mem_cnt--;
      end else if (imem_req) begin
        if (req_run == 0) cur_gnt_delay = rand_timing ? $urandom_range(0, 3) : gnt_cfg;
        req_run++;
        if (req_run > cur_gnt_delay) begin
          imem_gnt = 1'b1; last_req_run = req_run; req_run = 0;
          mem_pending = 1'b1; mem_addr = imem_addr;
          mem_cnt = rand_timing ? $urandom_range(0, 3) : lat_cfg;
        end
      end
      redirect = 1'b0;
      inst_ready = ($urandom_range(0, 99) < ready_pct);
      if (force_redir && ((force_in_wait && in_wait) || (!force_in_wait && inst_valid))) begin
        redirect = 1'b1; redirect_target = force_target; inst_ready = 1'b1; force_redir = 1'b0;
      end else if (redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
        redirect = 1'b1;
        if ($urandom_range(0, 9) == 0) redirect_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else redirect_target = $urandom & 32'h0000_3FFF;
      end
      if (redirect) begin
        exp_q.delete();
        exp_q.push_back(redirect_target & 32'hFFFF_FFFC);
      end else if (inst_ready && inst_valid) begin
        exp_q.push_back(cur_pc + 32'd4);
      end
      mis_exp = redirect && (redirect_target[1:0] != 2'b00);
    end
  end

  // Monitor: pops the scoreboard on each newly presented instruction
  initial begin : monitor
    logic        prev_valid = 1'b0;
    logic [31:0] prev_inst = 32'h0, prev_pc = 32'h0, e;
    int          stall = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        prev_valid = 1'b0; stall = 0;
        continue;
      end
      check("misalign_pulse", {31'd0, misalign}, {31'd0, mis_exp});
      if (misalign) saw_mis = 1'b1;
      if (inst_valid) check("no_req_while_holding", {31'd0, imem_req}, 32'd0);
      if (inst_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_instruction");
        end else begin
          e = exp_q.pop_front();
          cur_pc = e;
          check("inst_pc", inst_pc, e);
          check("inst_word", inst, mem_word(e));
        end
        pres_pc_q.push_back(inst_pc);
        pres_cyc_q.push_back(cyc);
        pres_cnt++;
      end else if (inst_valid) begin
        check("inst_stable", inst, prev_inst);
        check("inst_pc_stable", inst_pc, prev_pc);
      end
      stall = inst_valid ? 0 : stall + 1;
      if (stall > 200) begin
        fail("fetch_stalled");
        stall = 0;
      end
      prev_valid = inst_valid; prev_inst = inst; prev_pc = inst_pc;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] held;
    int spent;
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    exp_q.push_back(RESET_PC);
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #3 rst_n = 1'b1;

    // back-to-back fetch: memory answers in the second WAIT cycle -> one instruction per 4 cycles
    wait_pres(3, 200, "stream");
    check("stream_pc0", pres_pc_q[0], 32'h0);
    check("stream_pc1", pres_pc_q[1], 32'h4);
    check("stream_pc2", pres_pc_q[2], 32'h8);
    check("stream_period01", pres_cyc_q[1] - pres_cyc_q[0], 32'd4);
    check("stream_period12", pres_cyc_q[2] - pres_cyc_q[1], 32'd4);

    // consumer stalls five cycles on the presented instruction
    ready_pct = 0;
    held = pres_pc_q[$];
    repeat (5) @(posedge clk);
    #2;
    check("stall_valid", {31'd0, inst_valid}, 32'd1);
    check("stall_pc", inst_pc, held);
    ready_pct = 100;
    wait_pres(1, 200, "after_stall");
    check("after_stall_pc", pres_pc_q[$], held + 32'd4);

    // grant withheld for three cycles
    gnt_cfg = 3;
    wait_pres(1, 200, "slow_gnt");
    check("slow_gnt_req_cycles", last_req_run, 32'd4);
    check("slow_gnt_pc", pres_pc_q[$], held + 32'd8);
    gnt_cfg = 0;

    // redirect while the response is outstanding
    force_target = 32'h0000_0100; force_in_wait = 1'b1; force_redir = 1'b1;
    wait_force("wait_redirect");
    wait_pres(1, 200, "wait_redirect");
    check("wait_redirect_pc", pres_pc_q[$], 32'h0000_0100);

    // misaligned redirect in HOLD with ready high in the same cycle
    saw_mis = 1'b0;
    force_target = 32'h0000_0202; force_in_wait = 1'b0; force_redir = 1'b1;
    wait_force("hold_redirect");
    wait_pres(1, 200, "hold_redirect");
    check("hold_redirect_pc", pres_pc_q[$], 32'h0000_0200);
    check("hold_redirect_misalign_seen", {31'd0, saw_mis}, 32'd1);
    wait_pres(1, 200, "hold_redirect_next");
    check("hold_redirect_next_pc", pres_pc_q[$], 32'h0000_0204);

    // asynchronous reset while a fetch is outstanding
    spent = 0;
    do begin
      @(posedge clk); #2;
      spent++;
    end while (!mem_pending && spent < 200);
    if (!mem_pending) fail("reach_wait_timeout");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    force_redir = 1'b0;
    #3 rst_n = 1'b1;
    wait_pres(1, 200, "post_reset");
    check("post_reset_pc", pres_pc_q[$], RESET_PC);

    // randomized traffic: ready, grant delay, latency and redirects all random
    rand_timing = 1'b1; ready_pct = 50; redir_pct = 4;
    wait_pres(250, 20000, "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
